// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: holding-register state type and select range check for stream_demux
package stream_demux_pkg;
  typedef enum logic {EMPTY, FULL} demux_state_e;
  function automatic logic sel_valid(input int unsigned sel, input int unsigned num_out);
    return sel < num_out;
  endfunction
endpackage

// File: rtl/stream_demux.sv
// stream_demux: 1-to-NUM_OUT registered stream demux with saturating drop counter
// Define STREAM_DEMUX_SVA_EN to compile in the protocol assertions.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int NUM_OUT = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W = $clog2(NUM_OUT),
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SEL_W-1:0]   in_sel,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [CNT_W-1:0]   drop_cnt
);
  demux_state_e state;
  logic [DATA_W-1:0] data_q;
  logic [SEL_W-1:0] dest_q;
  logic accept, sel_ok;
  assign in_ready = (state == EMPTY) || out_ready[dest_q];
  assign accept = in_valid && in_ready;
  assign sel_ok = sel_valid(32'(in_sel), NUM_OUT);
  assign out_data = data_q;
  // in_ready already folds in the drain of the held beat, so a non-storing cycle with in_ready high in FULL empties it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      data_q <= '0;
      dest_q <= '0;
      out_valid <= '0;
      drop_cnt <= '0;
    end else begin
      if (accept && sel_ok) begin
        state <= FULL;
        data_q <= in_data;
        dest_q <= in_sel;
        out_valid <= NUM_OUT'(1) << in_sel;
      end else if (state == FULL && out_ready[dest_q]) begin
        state <= EMPTY;
        out_valid <= '0;
      end
      if (accept && !sel_ok && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end
`ifdef STREAM_DEMUX_SVA_EN
  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(out_valid))
    else $error("stream_demux: out_valid %b not onehot0", out_valid);
  a_drop_mono: assert property (@(posedge clk) disable iff (rst) !$past(rst) |-> drop_cnt >= $past(drop_cnt))
    else $error("stream_demux: drop_cnt decremented");
  for (genvar k = 0; k < NUM_OUT; k++) begin : g_sva
    a_stall: assert property (@(posedge clk) disable iff (rst)
      out_valid[k] && !out_ready[k] |=> $stable(out_data) && $stable(out_valid))
      else $error("stream_demux: lane %0d changed while stalled", k);
    a_route: assert property (@(posedge clk) disable iff (rst)
      accept && in_sel == SEL_W'(k) |=> out_valid[k] && out_data == $past(in_data))
      else $error("stream_demux: lane %0d misrouted", k);
  end
`endif
endmodule
